// File: rtl/pipereg_elastic.sv
// Elastic pipeline stage between CPU stages: valid/ready handshake, optional
// 2-entry skid buffer, synchronous flush and a saturating backpressure counter.
module pipereg_elastic #(
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned CTRL_W     = 10,
  parameter int unsigned SKID       = 1,
  parameter int unsigned CLEAR_DATA = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  bp_cycles
);

  localparam int unsigned OCC_W = 2;
  localparam logic [CNT_W-1:0] BP_MAX = '1;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
  } entry_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  entry_t             head_q, head_d;
  entry_t             skid_q, skid_d;
  entry_t             in_entry;
  logic               out_valid_q, out_valid_d;
  logic [OCC_W-1:0]   occ_q, occ_d;
  logic [CNT_W-1:0]   bp_q, bp_d;
  logic               in_fire;
  logic               out_fire;

  // A bubble always carries zero control; data is zeroed or kept stale.
  function automatic entry_t bubble(input entry_t cur);
    entry_t b;
    b = '0;
    if (CLEAR_DATA == 0) b.data = cur.data;
    return b;
  endfunction

  assign in_entry.ctrl = in_ctrl;
  assign in_entry.data = in_data;
  assign in_fire       = in_valid & in_ready;
  assign out_fire      = out_valid_q & out_ready;

  // Next-state, next-entry and counter logic
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    bp_d    = bp_q;

    if (out_valid_q && !out_ready && (bp_q != BP_MAX)) bp_d = bp_q + CNT_W'(1);

    if (flush) begin
      state_d = ST_EMPTY;
      head_d  = bubble(head_q);
      skid_d  = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d = ST_ONE;
            head_d  = in_entry;
          end
        end
        ST_ONE: begin
          if (in_fire && !out_fire && (SKID != 0)) begin
            state_d = ST_FULL;
            skid_d  = in_entry;
          end else if (in_fire) begin
            head_d  = in_entry;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
            head_d  = bubble(head_q);
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            state_d = ST_ONE;
            head_d  = skid_q;
            skid_d  = '0;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          head_d  = bubble(head_q);
          skid_d  = '0;
        end
      endcase
    end

    out_valid_d = (state_d != ST_EMPTY);
    occ_d       = OCC_W'(state_d);
  end

  // Stage registers; reset drops every held entry immediately
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= ST_EMPTY;
      head_q      <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      occ_q       <= '0;
      bp_q        <= '0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      skid_q      <= skid_d;
      out_valid_q <= out_valid_d;
      occ_q       <= occ_d;
      bp_q        <= bp_d;
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      logic in_ready_q;

      // Registered ready: the skid entry absorbs the one-cycle ready lag
      always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) in_ready_q <= 1'b0;
        else       in_ready_q <= (state_d != ST_FULL);
      end

      assign in_ready = in_ready_q;
    end else begin : g_noskid
      assign in_ready = nrst & (out_ready | ~out_valid_q);
    end
  endgenerate

  assign out_valid = out_valid_q;
  assign out_data  = head_q.data;
  assign out_ctrl  = head_q.ctrl;
  assign occupancy = occ_q;
  assign bp_cycles = bp_q;

endmodule

// File: tb/tb_pipereg_elastic.sv
// Scoreboard bench for pipereg_elastic: SKID=1/CLEAR_DATA=1/CNT_W=4 instance
// checked through a queue-driven monitor, plus a SKID=0/CLEAR_DATA=0 instance.
module tb_pipereg_elastic;

  localparam int unsigned DW = 64;
  localparam int unsigned CW = 10;

  typedef struct packed {
    logic [CW-1:0] ctrl;
    logic [DW-1:0] data;
  } exp_t;

  logic clk  = 1'b0;
  logic nrst = 1'b1;
  always #5 clk = ~clk;

  // instance 0: skid buffer, cleared bubbles, 4-bit counter
  logic          flush0 = 1'b0, in_valid0 = 1'b0, out_ready0 = 1'b0;
  logic          in_ready0, out_valid0;
  logic [DW-1:0] in_data0 = '0, out_data0;
  logic [CW-1:0] in_ctrl0 = '0, out_ctrl0;
  logic [1:0]    occ0;
  logic [3:0]    bp0;

  // instance 1: single register, stale data on bubbles
  logic          flush1 = 1'b0, in_valid1 = 1'b0, out_ready1 = 1'b1;
  logic          in_ready1, out_valid1;
  logic [DW-1:0] in_data1 = '0, out_data1;
  logic [CW-1:0] in_ctrl1 = '0, out_ctrl1;
  logic [1:0]    occ1;
  logic [15:0]   bp1;

  pipereg_elastic #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CLEAR_DATA(1), .CNT_W(4)) u0 (
    .clk(clk), .nrst(nrst), .flush(flush0),
    .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0), .in_ctrl(in_ctrl0),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0), .out_ctrl(out_ctrl0),
    .occupancy(occ0), .bp_cycles(bp0)
  );

  pipereg_elastic #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CLEAR_DATA(0), .CNT_W(16)) u1 (
    .clk(clk), .nrst(nrst), .flush(flush1),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1), .in_ctrl(in_ctrl1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1), .out_ctrl(out_ctrl1),
    .occupancy(occ1), .bp_cycles(bp1)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Offer one entry to instance 0 and hold it until accepted (bounded)
  task automatic send0(input logic [63:0] d, input logic [CW-1:0] c, input bit expect_out);
    int k;
    if (expect_out) sb.push_back(exp_t'({c, d}));
    in_valid0 = 1'b1;
    in_data0  = d;
    in_ctrl0  = c;
    k = 0;
    @(negedge clk);
    while (!in_ready0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready0) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: data 0x%0h never accepted", d);
    end
    @(posedge clk);
    #1;
    in_valid0 = 1'b0;
  endtask

  // Monitor: pops expected entries on every downstream fire of instance 0
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (nrst) begin
        if (out_valid0 && out_ready0) begin
          if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_out: got data 0x%0h, expected no entry", out_data0);
          end else begin
            e = sb.pop_front();
            chk("sb_data", out_data0, e.data);
            chk("sb_ctrl", 64'(out_ctrl0), 64'(e.ctrl));
          end
        end
        if (!out_valid0) begin
          chk("bubble_ctrl", 64'(out_ctrl0), 64'd0);
          chk("bubble_data", out_data0, 64'd0);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // reset state
    #1 nrst = 1'b0;
    #2;
    chk("rst_out_valid", 64'(out_valid0), 64'd0);
    chk("rst_occ", 64'(occ0), 64'd0);
    chk("rst_in_ready", 64'(in_ready0), 64'd0);
    chk("rst_bp", 64'(bp0), 64'd0);
    chk("rst_in_ready1", 64'(in_ready1), 64'd0);
    @(negedge clk);
    #2 nrst = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_in_ready", 64'(in_ready0), 64'd1);

    // streaming at full rate, 1-cycle latency
    out_ready0 = 1'b1;
    send0(64'h11, 10'h3FF, 1'b1);
    chk("lat_out_valid", 64'(out_valid0), 64'd1);
    chk("lat_out_data", out_data0, 64'h11);
    for (int i = 1; i < 4; i++) begin
      send0(64'h11 + 64'(i), 10'h3FF, 1'b1);
      chk("stream_occ", 64'(occ0), 64'd1);
    end
    @(posedge clk);
    #1;
    chk("stream_drain_occ", 64'(occ0), 64'd0);
    chk("stream_bp", 64'(bp0), 64'd0);

    // backpressure fills the skid entry; order must be preserved
    fork
      begin
        send0(64'hA0, 10'h001, 1'b1);
        send0(64'hA1, 10'h002, 1'b1);
        send0(64'hA2, 10'h003, 1'b1);
      end
      begin
        @(posedge clk);
        #1 out_ready0 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("bp_full_occ", 64'(occ0), 64'd2);
        chk("bp_full_in_ready", 64'(in_ready0), 64'd0);
        repeat (3) @(posedge clk);
        #1 out_ready0 = 1'b1;
        @(negedge clk);
        chk("bp_count", 64'(bp0), 64'd4);
      end
    join
    repeat (3) @(posedge clk);
    #1;
    chk("bp_drain_occ", 64'(occ0), 64'd0);
    chk("bp_hold", 64'(bp0), 64'd4);
    chk("bp_sb_empty", 64'(sb.size()), 64'd0);

    // flush while full, with an offered entry that must vanish
    out_ready0 = 1'b0;
    send0(64'hD0, 10'h3FF, 1'b0);
    send0(64'hD1, 10'h3FF, 1'b0);
    chk("fl_pre_occ", 64'(occ0), 64'd2);
    flush0    = 1'b1;
    in_valid0 = 1'b1;
    in_data0  = 64'hB0;
    in_ctrl0  = 10'h3FF;
    @(posedge clk);
    #1;
    flush0    = 1'b0;
    in_valid0 = 1'b0;
    chk("fl_out_valid", 64'(out_valid0), 64'd0);
    chk("fl_out_ctrl", 64'(out_ctrl0), 64'd0);
    chk("fl_out_data", out_data0, 64'd0);
    chk("fl_occ", 64'(occ0), 64'd0);
    chk("fl_in_ready", 64'(in_ready0), 64'd1);
    chk("fl_bp_kept", 64'(bp0), 64'd6);

    // flush discards an entry accepted in the same cycle
    send0(64'hE0, 10'h155, 1'b0);
    flush0    = 1'b1;
    in_valid0 = 1'b1;
    in_data0  = 64'hE1;
    @(posedge clk);
    #1;
    flush0    = 1'b0;
    in_valid0 = 1'b0;
    chk("fl2_occ", 64'(occ0), 64'd0);
    out_ready0 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("fl2_idle_valid", 64'(out_valid0), 64'd0);
    chk("fl2_bp", 64'(bp0), 64'd7);

    // counter saturation at 15
    out_ready0 = 1'b0;
    send0(64'hF0, 10'h2AA, 1'b1);
    repeat (7) @(posedge clk);
    #1 chk("sat_below", 64'(bp0), 64'd14);
    repeat (14) @(posedge clk);
    #1 chk("sat_max", 64'(bp0), 64'd15);
    out_ready0 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("sat_occ", 64'(occ0), 64'd0);
    chk("sat_stays", 64'(bp0), 64'd15);

    // single-register instance: stale data on bubble, combinational ready
    in_valid1 = 1'b1;
    in_data1  = 64'hC5;
    in_ctrl1  = 10'h155;
    @(negedge clk);
    chk("ns_in_ready_empty", 64'(in_ready1), 64'd1);
    @(posedge clk);
    #1 in_valid1 = 1'b0;
    chk("ns_out_valid", 64'(out_valid1), 64'd1);
    chk("ns_out_data", out_data1, 64'hC5);
    chk("ns_out_ctrl", 64'(out_ctrl1), 64'h155);
    chk("ns_occ", 64'(occ1), 64'd1);
    @(posedge clk);
    #1;
    chk("ns_bub_valid", 64'(out_valid1), 64'd0);
    chk("ns_bub_ctrl", 64'(out_ctrl1), 64'd0);
    chk("ns_bub_stale", out_data1, 64'hC5);
    chk("ns_bub_occ", 64'(occ1), 64'd0);
    out_ready1 = 1'b0;
    in_valid1  = 1'b1;
    in_data1   = 64'hC6;
    @(posedge clk);
    #1 in_valid1 = 1'b0;
    chk("ns_stall_ready", 64'(in_ready1), 64'd0);
    out_ready1 = 1'b1;
    #1 chk("ns_comb_ready", 64'(in_ready1), 64'd1);
    in_valid1 = 1'b1;
    in_data1  = 64'hC7;
    @(posedge clk);
    #1 in_valid1 = 1'b0;
    chk("ns_pass_data", out_data1, 64'hC7);
    chk("ns_pass_occ", 64'(occ1), 64'd1);
    @(posedge clk);
    #1;
    chk("ns_end_stale", out_data1, 64'hC7);
    chk("ns_bp", 64'(bp1), 64'd0);

    // asynchronous reset while full, then recovery
    out_ready0 = 1'b0;
    send0(64'h60, 10'h0F0, 1'b0);
    send0(64'h61, 10'h0F0, 1'b0);
    chk("ar_pre_occ", 64'(occ0), 64'd2);
    #2 nrst = 1'b0;
    #1;
    chk("ar_out_valid", 64'(out_valid0), 64'd0);
    chk("ar_occ", 64'(occ0), 64'd0);
    chk("ar_out_ctrl", 64'(out_ctrl0), 64'd0);
    chk("ar_out_data", out_data0, 64'd0);
    chk("ar_in_ready", 64'(in_ready0), 64'd0);
    chk("ar_bp", 64'(bp0), 64'd0);
    @(negedge clk);
    #2 nrst = 1'b1;
    @(posedge clk);
    #1;
    chk("ar_rel_in_ready", 64'(in_ready0), 64'd1);
    out_ready0 = 1'b1;
    send0(64'h77, 10'h00F, 1'b1);
    chk("ar_first_valid", 64'(out_valid0), 64'd1);
    chk("ar_first_data", out_data0, 64'h77);
    @(posedge clk);
    #1;
    chk("ar_drain_occ", 64'(occ0), 64'd0);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
